// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

    // Fetch unit state: normal sequencing or halted on a misaligned target.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } pc_state_t;

    localparam int PC_INCR         = 4;
    localparam int JUMP_REGION_LSB = 28;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A byte address is a legal fetch target only when it is word-aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_select.sv
// Next-PC selection: sequential increment, priority mux over the redirect
// sources, J-type region splice and the alignment flag for the chosen target.
module npc_select
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [27:0]       jump_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] jump_pc;

    // Sequential address wraps naturally at 2^ADDR_W.
    assign pc_plus4 = pc + ADDR_W'(PC_INCR);

    // J/JAL keep the region bits of the delay-slot address; narrow PCs have
    // no region bits, so the target is simply truncated to the PC width.
    generate
        if (ADDR_W > JUMP_REGION_LSB) begin : g_region
            assign jump_pc = {pc_plus4[ADDR_W-1:JUMP_REGION_LSB], jump_target};
        end else begin : g_no_region
            assign jump_pc = jump_target[ADDR_W-1:0];
        end
    endgenerate

    // Priority: jr, then jump, then branch, then fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Checked on every path, even the ones aligned by construction.
    assign misaligned = is_misaligned(next_pc[1:0]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter register, fetch-address generation and misalignment trap.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [27:0]       jump_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-3:0] imem_addr,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [31:0]       instr_count
);

    pc_state_t         state;
    pc_state_t         state_next;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;
    logic              pc_load;
    logic              fault_load;

    npc_select #(
        .ADDR_W (ADDR_W)
    ) u_npc_select (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // State register; FAULT is only left through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and register enables. A stalled cycle neither advances nor
    // checks alignment, so a misaligned target is only trapped once it would
    // actually be taken.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        fault_load = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_next = FAULT;
                        fault_load = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // PC and retired-update counter advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_count <= '0;
        end else if (pc_load) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
        end
    end

    // Capture the offending target on the trapping edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pc <= '0;
        end else if (fault_load) begin
            fault_pc <= next_pc;
        end
    end

    assign fault     = (state == FAULT);
    assign imem_addr = pc[ADDR_W-1:2];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RST_PC   = 32'h0040_0000;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [27:0]       jump_target;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-3:0] imem_addr;
    logic              fault;
    logic [ADDR_W-1:0] fault_pc;
    logic [31:0]       instr_count;

    int tests_run;
    int tests_failed;

    fetch_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .imem_addr     (imem_addr),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        jr            = 1'b0;
        jr_target     = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"},     64'(pc),          64'h0040_0000);
        check_eq({tag, "_imem"},   64'(imem_addr),   64'h0010_0000);
        check_eq({tag, "_pc4"},    64'(pc_plus4),    64'h0040_0004);
        check_eq({tag, "_fault"},  64'(fault),       64'h0);
        check_eq({tag, "_fpc"},    64'(fault_pc),    64'h0);
        check_eq({tag, "_count"},  64'(instr_count), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] seq_pc [3];
        tests_run    = 0;
        tests_failed = 0;
        seq_pc[0] = 32'h0040_0004;
        seq_pc[1] = 32'h0040_0008;
        seq_pc[2] = 32'h0040_000C;
        idle_inputs();

        rst = 1'b1;
        #2;
        check_reset_values("por");
        rst = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("seq_pc%0d", i), 64'(pc), 64'(seq_pc[i]));
        end
        check_eq("seq_imem",  64'(imem_addr),   64'h0010_0003);
        check_eq("seq_count", 64'(instr_count), 64'd3);
        check_eq("seq_pc4",   64'(pc_plus4),    64'h0040_0010);

        // Branch to region 1, then jump within it
        branch_taken  = 1'b1;
        branch_target = 32'h1000_0000;
        tick();
        check_eq("br_pc", 64'(pc), 64'h1000_0000);
        idle_inputs();
        jump        = 1'b1;
        jump_target = 28'h0ABC_DEF0;
        tick();
        check_eq("jmp_pc",    64'(pc),          64'h1ABC_DEF0);
        check_eq("jmp_count", 64'(instr_count), 64'd5);

        // All selects at once: jr wins
        idle_inputs();
        jr            = 1'b1;
        jr_target     = 32'h0000_0100;
        jump          = 1'b1;
        jump_target   = 28'h0123_4560;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2000;
        tick();
        check_eq("prio_pc",    64'(pc),          64'h0000_0100);
        check_eq("prio_count", 64'(instr_count), 64'd6);

        // Stall masks a misaligned branch target
        idle_inputs();
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0003;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("stall_fault%0d", i), 64'(fault), 64'h0);
            check_eq($sformatf("stall_pc%0d", i),    64'(pc),    64'h0000_0100);
        end
        check_eq("stall_count", 64'(instr_count), 64'd6);
        stall = 1'b0;
        tick();
        check_eq("unstall_fault", 64'(fault),       64'h1);
        check_eq("unstall_fpc",   64'(fault_pc),    64'h0000_0003);
        check_eq("unstall_pc",    64'(pc),          64'h0000_0100);
        check_eq("unstall_count", 64'(instr_count), 64'd6);

        do_reset();
        idle_inputs();

        // Misaligned jr traps; FAULT then ignores valid selects
        #1;
        jr        = 1'b1;
        jr_target = 32'h0000_0102;
        tick();
        check_eq("jr_fault", 64'(fault),       64'h1);
        check_eq("jr_fpc",   64'(fault_pc),    64'h0000_0102);
        check_eq("jr_pc",    64'(pc),          64'h0040_0000);
        check_eq("jr_count", 64'(instr_count), 64'd0);
        idle_inputs();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("hold_pc%0d", i),    64'(pc),       64'h0040_0000);
            check_eq($sformatf("hold_fault%0d", i), 64'(fault),    64'h1);
            check_eq($sformatf("hold_fpc%0d", i),   64'(fault_pc), 64'h0000_0102);
        end
        check_eq("hold_count", 64'(instr_count), 64'd0);

        do_reset();
        idle_inputs();

        // Wrap from the top of the address space
        #1;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        check_eq("top_pc",  64'(pc),       64'hFFFF_FFFC);
        check_eq("top_pc4", 64'(pc_plus4), 64'h0000_0000);
        idle_inputs();
        tick();
        check_eq("wrap_pc",    64'(pc),          64'h0000_0000);
        check_eq("wrap_fault", 64'(fault),       64'h0);
        check_eq("wrap_count", 64'(instr_count), 64'd2);

        // Trap, then reset asynchronously mid-cycle
        jr        = 1'b1;
        jr_target = 32'h0000_0001;
        tick();
        check_eq("pre_async_fault", 64'(fault), 64'h1);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_pc", 64'(pc), 64'h0040_0004);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-address unit for the single-cycle MIPS CPU. Holds the byte-addressed PC, selects the next PC from sequential, branch, jump and jump-register sources, and converts the byte PC into a word index for instruction memory. It checks the low two address bits and traps misaligned targets into a halted fault state. It sits between the control/branch logic, which supplies the shifted targets, and the instruction memory.

## Interface
- `ADDR_W`, 32: PC width in bits. `ADDR_W` must be at least 8.
- `RESET_PC`, 0: PC value loaded on reset. Must be word-aligned.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: holds the PC and counter. Target inputs are ignored while high.
- `branch_taken`  in  1: take `branch_target`.
- `branch_target`  in  ADDR_W: byte address of the branch target.
- `jump`  in  1: take the J/JAL target.
- `jump_target`  in  28: byte offset within the current 256 MB region, already shifted left by 2.
- `jr`  in  1: take `jr_target`.
- `jr_target`  in  ADDR_W: register value. It may be misaligned.
- `pc`  out  ADDR_W: current PC, registered.
- `pc_plus4`  out  ADDR_W: `pc + 4`, combinational.
- `imem_addr`  out  ADDR_W-2: word index `pc[ADDR_W-1:2]`, combinational from the PC register.
- `fault`  out  1: misalignment trap, sticky until reset.
- `fault_pc`  out  ADDR_W: the offending target address.
- `instr_count`  out  32: number of PC updates since reset.

## Operation
- States: `RUN` and `FAULT`.
- Next-PC priority, highest first: `jr`, `jump`, `branch_taken`, then sequential.
  - `jr`: `jr_target`.
  - `jump`: `{pc_plus4[ADDR_W-1:28], jump_target}`.
  - `branch_taken`: `branch_target`.
  - Sequential: `pc_plus4`.
  - Multiple selects asserted at once: the highest priority wins. This is not an error.
- Arithmetic: `pc + 4` is modulo 2^ADDR_W. From `0xFFFF_FFFC` it wraps to `0x0000_0000` with no fault.
- `RUN` with `stall=0` and `next_pc[1:0]==0`:
  - PC takes `next_pc`.
  - `instr_count` increments, wrapping at 2^32.
- `RUN` with `stall=0` and `next_pc[1:0]!=0`:
  - PC holds; `instr_count` holds.
  - `fault_pc` loads `next_pc` and `fault` sets.
  - State goes to `FAULT`.
- `RUN` with `stall=1`:
  - PC, `instr_count` and state all hold.
  - No alignment check is made, even if a target is misaligned.
- `FAULT`:
  - PC, `instr_count`, `fault_pc` and `fault=1` hold regardless of any input.
  - Only `rst` exits this state.
- The sequential and jump paths are aligned by construction. The check is still applied uniformly to every path.

## Timing
- Reset values, applied asynchronously while `rst=1`:
  - `pc=RESET_PC`
  - `imem_addr=RESET_PC>>2`
  - `pc_plus4=RESET_PC+4`
  - `fault=0`, `fault_pc=0`, `instr_count=0`
  - state `RUN`
- Reset asserted mid-operation, including in `FAULT`, takes effect immediately without waiting for a clock edge. Release is synchronous to the next rising edge.
- `next_pc` is combinational from the current inputs. The PC updates on the rising edge, so the new `pc` and `imem_addr` are visible one cycle after the select inputs are sampled.
- `imem_addr` and `pc_plus4` have zero latency relative to `pc`.
- `fault` and `fault_pc` are registered. Both become visible on the edge that samples the misaligned target; `pc` is unchanged on that same edge.
- There is no handshake: `stall` is a level, sampled on each rising edge.

## Structure
- Shared package `mips_pkg`:
  - `pc_state_t` enum (`RUN`, `FAULT`).
  - `PC_INCR = 4`.
  - Default `RESET_PC`.
  - `JUMP_REGION_LSB = 28`.
- One natural sub-module: `npc_select`. It is combinational: priority mux plus region concatenation plus the misalignment flag. The state register, PC register and counter stay in `fetch_pc_unit`.

## Test plan
- Reset with `RESET_PC=0x0040_0000`, then three cycles with no selects:
  - `pc` steps `0x0040_0004`, `0x0040_0008`, `0x0040_000C`.
  - `imem_addr` ends at `0x0010_0003`.
  - `instr_count=3`.
- `pc=0x1000_0000`, `jump=1`, `jump_target=0x0ABC_DEF0` -> next `pc=0x1ABC_DEF0`.
- `jr=1`, `jump=1`, `branch_taken=1` together with `jr_target=0x0000_0100` -> `pc=0x0000_0100` (jr wins).
- `jr=1`, `jr_target=0x0000_0102`:
  - Next edge: `fault=1`, `fault_pc=0x0000_0102`, `pc` unchanged, `instr_count` unchanged.
  - Five further cycles of valid selects: all outputs hold.
- `stall=1` with `branch_taken=1` and a misaligned `branch_target=0x0000_0003` for two cycles -> no fault, `pc` holds. Releasing `stall` with the target unchanged -> fault on the next edge.
- `pc=0xFFFF_FFFC`, no selects -> `pc=0x0000_0000`, no fault. Then assert `rst` asynchronously mid-cycle while in `FAULT` -> all reset values appear immediately.
